// File: rtl/reg_file_banked_if.sv
// Bus between the register control unit and the banked GP register file.
interface reg_file_banked_if #(
  parameter int unsigned BYTE_W    = 8,
  parameter int unsigned NUM_PAIRS = 8
);
  localparam int unsigned IDX_W  = $clog2(NUM_PAIRS);
  localparam int unsigned PAIR_W = 2 * BYTE_W;

  logic [IDX_W-1:0]  wr_sel;
  logic              wr_hi;
  logic              wr_lo;
  logic [PAIR_W-1:0] wr_data;
  logic [IDX_W-1:0]  rd_sel_a;
  logic [PAIR_W-1:0] rd_data_a;
  logic [IDX_W-1:0]  rd_sel_b;
  logic [PAIR_W-1:0] rd_data_b;
  logic              ex_af;
  logic              exx;
  logic              ex_dehl;
  logic              incdec_en;
  logic              incdec_dn;
  logic [IDX_W-1:0]  incdec_sel;
  logic              af_bank;
  logic              gp_bank;
  logic [1:0]        dehl_swap;

  modport master (
    output wr_sel, wr_hi, wr_lo, wr_data, rd_sel_a, rd_sel_b,
    output ex_af, exx, ex_dehl, incdec_en, incdec_dn, incdec_sel,
    input  rd_data_a, rd_data_b, af_bank, gp_bank, dehl_swap
  );

  modport slave (
    input  wr_sel, wr_hi, wr_lo, wr_data, rd_sel_a, rd_sel_b,
    input  ex_af, exx, ex_dehl, incdec_en, incdec_dn, incdec_sel,
    output rd_data_a, rd_data_b, af_bank, gp_bank, dehl_swap
  );
endinterface

// File: rtl/reg_file_banked.sv
// Banked GP register file: AF/AF', BC/DE/HL with alternate set and DE/HL swap,
// two combinational read ports, byte-masked write and in-place +/-1 on a pair.
module reg_file_banked #(
  parameter int unsigned       BYTE_W    = 8,
  parameter int unsigned       NUM_PAIRS = 8,
  parameter logic [2*BYTE_W-1:0] RESET_VAL = '1
) (
  input logic              clk,
  input logic              nreset,
  reg_file_banked_if.slave bus
);
  localparam int unsigned IDX_W    = $clog2(NUM_PAIRS);
  localparam int unsigned PAIR_W   = 2 * BYTE_W;
  // Physical slots: 0..NUM_PAIRS-1 hold AF0/BC0/DE0/HL0 and the plain pairs,
  // NUM_PAIRS..NUM_PAIRS+3 hold AF1/BC1/DE1/HL1.
  localparam int unsigned NUM_PHYS = NUM_PAIRS + 4;
  localparam int unsigned PHYS_W   = $clog2(NUM_PHYS);
  localparam logic [PHYS_W-1:0] ALT = PHYS_W'(NUM_PAIRS);

  logic [PAIR_W-1:0] r_pair_q [NUM_PHYS];
  logic [PAIR_W-1:0] w_pair_d [NUM_PHYS];
  logic              r_af_bank_q, w_af_bank_d;
  logic              r_gp_bank_q, w_gp_bank_d;
  logic [1:0]        r_dehl_swap_q, w_dehl_swap_d;

  logic              w_swp_cur;
  logic [PHYS_W-1:0] w_wr_phys, w_inc_phys, w_rd_phys_a, w_rd_phys_b;
  logic              w_wr_ok, w_inc_ok, w_rd_ok_a, w_rd_ok_b;
  logic [PAIR_W-1:0] w_inc_res;

  // Logical pair index to physical slot through the current bank/swap state.
  function automatic logic [PHYS_W-1:0] map_idx(input logic [IDX_W-1:0] idx,
                                                 input logic afb, input logic gpb,
                                                 input logic swp);
    logic [PHYS_W-1:0] base;
    base    = gpb ? ALT : '0;
    map_idx = PHYS_W'(idx);
    if (idx == IDX_W'(0))      map_idx = afb ? ALT : '0;
    else if (idx == IDX_W'(1)) map_idx = base + PHYS_W'(1);
    else if (idx == IDX_W'(2)) map_idx = base + (swp ? PHYS_W'(3) : PHYS_W'(2));
    else if (idx == IDX_W'(3)) map_idx = base + (swp ? PHYS_W'(2) : PHYS_W'(3));
    return map_idx;
  endfunction

  assign w_swp_cur   = r_dehl_swap_q[r_gp_bank_q];
  assign w_wr_phys   = map_idx(bus.wr_sel, r_af_bank_q, r_gp_bank_q, w_swp_cur);
  assign w_inc_phys  = map_idx(bus.incdec_sel, r_af_bank_q, r_gp_bank_q, w_swp_cur);
  assign w_rd_phys_a = map_idx(bus.rd_sel_a, r_af_bank_q, r_gp_bank_q, w_swp_cur);
  assign w_rd_phys_b = map_idx(bus.rd_sel_b, r_af_bank_q, r_gp_bank_q, w_swp_cur);
  assign w_wr_ok     = (32'(bus.wr_sel) < NUM_PAIRS) && (bus.wr_hi || bus.wr_lo);
  assign w_inc_ok    = (32'(bus.incdec_sel) < NUM_PAIRS) && bus.incdec_en;
  assign w_rd_ok_a   = 32'(bus.rd_sel_a) < NUM_PAIRS;
  assign w_rd_ok_b   = 32'(bus.rd_sel_b) < NUM_PAIRS;

  assign w_inc_res = bus.incdec_dn ? r_pair_q[w_inc_phys] - PAIR_W'(1)
                                   : r_pair_q[w_inc_phys] + PAIR_W'(1);

  // Read ports see pre-edge contents; out-of-range selects read zero.
  assign bus.rd_data_a = w_rd_ok_a ? r_pair_q[w_rd_phys_a] : '0;
  assign bus.rd_data_b = w_rd_ok_b ? r_pair_q[w_rd_phys_b] : '0;
  assign bus.af_bank   = r_af_bank_q;
  assign bus.gp_bank   = r_gp_bank_q;
  assign bus.dehl_swap = r_dehl_swap_q;

  // Next pair contents: inc/dec result first, then enabled write bytes override it.
  always_comb begin
    for (int p = 0; p < NUM_PHYS; p++) begin
      w_pair_d[p] = r_pair_q[p];
      if (w_inc_ok && (w_inc_phys == PHYS_W'(p))) w_pair_d[p] = w_inc_res;
      if (w_wr_ok && (w_wr_phys == PHYS_W'(p))) begin
        if (bus.wr_hi) w_pair_d[p][PAIR_W-1:BYTE_W] = bus.wr_data[PAIR_W-1:BYTE_W];
        if (bus.wr_lo) w_pair_d[p][BYTE_W-1:0]      = bus.wr_data[BYTE_W-1:0];
      end
    end
  end

  // Next bank/swap state; ex_dehl acts on the pre-edge GP bank.
  always_comb begin
    w_af_bank_d                = r_af_bank_q ^ bus.ex_af;
    w_gp_bank_d                = r_gp_bank_q ^ bus.exx;
    w_dehl_swap_d              = r_dehl_swap_q;
    w_dehl_swap_d[r_gp_bank_q] = r_dehl_swap_q[r_gp_bank_q] ^ bus.ex_dehl;
  end

  // State registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int p = 0; p < NUM_PHYS; p++) r_pair_q[p] <= RESET_VAL;
      r_af_bank_q   <= 1'b0;
      r_gp_bank_q   <= 1'b0;
      r_dehl_swap_q <= 2'b00;
    end else begin
      for (int p = 0; p < NUM_PHYS; p++) r_pair_q[p] <= w_pair_d[p];
      r_af_bank_q   <= w_af_bank_d;
      r_gp_bank_q   <= w_gp_bank_d;
      r_dehl_swap_q <= w_dehl_swap_d;
    end
  end
endmodule

// File: tb/tb_reg_file_banked.sv
// Bench for reg_file_banked: spec-level model checked every cycle plus literal checks.
module tb_reg_file_banked;
  logic clk;
  logic nreset;
  bit   chk_en;
  int   n_tests;
  int   n_fail;

  reg_file_banked_if #(.BYTE_W(8), .NUM_PAIRS(8)) m_if ();
  reg_file_banked_if #(.BYTE_W(8), .NUM_PAIRS(5)) s_if ();

  reg_file_banked #(.BYTE_W(8), .NUM_PAIRS(8), .RESET_VAL(16'hFFFF)) u_dut (
    .clk(clk), .nreset(nreset), .bus(m_if.slave)
  );
  reg_file_banked #(.BYTE_W(8), .NUM_PAIRS(5), .RESET_VAL(16'hFFFF)) u_dut5 (
    .clk(clk), .nreset(nreset), .bus(s_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model storage: slot 0/1 = AF/AF', 2..4 = BC/DE/HL bank0, 5..7 bank1, 8+i = pair i.
  logic [15:0] m_reg [16];
  logic        m_afb, m_gpb;
  logic [1:0]  m_swap;

  function automatic int m_slot(input int l);
    int g;
    g = 2 + 3 * int'(m_gpb);
    case (l)
      0:       return m_afb ? 1 : 0;
      1:       return g;
      2:       return g + (m_swap[m_gpb] ? 2 : 1);
      3:       return g + (m_swap[m_gpb] ? 1 : 2);
      default: return 8 + l;
    endcase
  endfunction

  function automatic logic [15:0] m_read(input int l);
    if (l >= 8) return 16'h0000;
    return m_reg[m_slot(l)];
  endfunction

  // Value logical pair l takes at the edge given the current inputs.
  function automatic logic [15:0] m_next(input int l);
    logic [15:0] v;
    v = m_read(l);
    if (m_if.incdec_en && int'(m_if.incdec_sel) == l) v = m_if.incdec_dn ? v - 1 : v + 1;
    if (int'(m_if.wr_sel) == l) begin
      if (m_if.wr_hi) v[15:8] = m_if.wr_data[15:8];
      if (m_if.wr_lo) v[7:0]  = m_if.wr_data[7:0];
    end
    return v;
  endfunction

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < 16; i++) m_reg[i] <= 16'hFFFF;
      m_afb  <= 1'b0;
      m_gpb  <= 1'b0;
      m_swap <= 2'b00;
    end else begin
      if (m_if.wr_hi || m_if.wr_lo)
        m_reg[m_slot(int'(m_if.wr_sel))] <= m_next(int'(m_if.wr_sel));
      if (m_if.incdec_en)
        m_reg[m_slot(int'(m_if.incdec_sel))] <= m_next(int'(m_if.incdec_sel));
      m_afb <= m_afb ^ m_if.ex_af;
      m_gpb <= m_gpb ^ m_if.exx;
      if (m_if.ex_dehl) m_swap[m_gpb] <= ~m_swap[m_gpb];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_rd_a", 32'(m_if.rd_data_a), 32'(m_read(int'(m_if.rd_sel_a))));
      check("model_rd_b", 32'(m_if.rd_data_b), 32'(m_read(int'(m_if.rd_sel_b))));
      check("model_banks", {28'd0, m_if.af_bank, m_if.gp_bank, m_if.dehl_swap},
            {28'd0, m_afb, m_gpb, m_swap});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    m_if.wr_hi = 1'b0; m_if.wr_lo = 1'b0; m_if.ex_af = 1'b0; m_if.exx = 1'b0;
    m_if.ex_dehl = 1'b0; m_if.incdec_en = 1'b0; m_if.incdec_dn = 1'b0;
  endtask

  task automatic wr(input int sel, input logic [15:0] d, input logic hi, input logic lo);
    m_if.wr_sel = 3'(sel); m_if.wr_data = d; m_if.wr_hi = hi; m_if.wr_lo = lo;
    cyc();
    idle();
  endtask

  task automatic rd_lit(input string name, input int sel, input logic [15:0] exp);
    m_if.rd_sel_a = 3'(sel);
    m_if.rd_sel_b = 3'(sel);
    #1;
    check({name, "_a"}, 32'(m_if.rd_data_a), 32'(exp));
    check({name, "_b"}, 32'(m_if.rd_data_b), 32'(exp));
  endtask

  task automatic bank_lit(input string name, input logic [3:0] exp);
    #1;
    check(name, {28'd0, m_if.af_bank, m_if.gp_bank, m_if.dehl_swap}, {28'd0, exp});
  endtask

  task automatic s_lit(input string name, input int sel, input logic [15:0] exp);
    s_if.rd_sel_a = 3'(sel);
    #1;
    check(name, 32'(s_if.rd_data_a), 32'(exp));
  endtask

  initial begin
    n_tests = 0; n_fail = 0; chk_en = 1'b0;
    m_if.wr_sel = '0; m_if.wr_data = '0; m_if.rd_sel_a = '0; m_if.rd_sel_b = '0;
    m_if.incdec_sel = '0;
    idle();
    s_if.wr_sel = '0; s_if.wr_hi = 1'b0; s_if.wr_lo = 1'b0; s_if.wr_data = '0;
    s_if.rd_sel_a = '0; s_if.rd_sel_b = '0; s_if.ex_af = 1'b0; s_if.exx = 1'b0;
    s_if.ex_dehl = 1'b0; s_if.incdec_en = 1'b0; s_if.incdec_dn = 1'b0; s_if.incdec_sel = '0;
    nreset = 1'b1;
    #1 nreset = 1'b0;
    cyc();
    // Reset contents on every index, both ports.
    for (int i = 0; i < 8; i++) rd_lit("reset_rd", i, 16'hFFFF);
    bank_lit("reset_banks", 4'b0000);
    nreset = 1'b1;
    chk_en = 1'b1;
    cyc();

    // Byte writes.
    wr(0, 16'h3412, 1'b1, 1'b1);
    wr(0, 16'h9956, 1'b0, 1'b1);
    rd_lit("af_lo_only", 0, 16'h3456);
    wr(0, 16'h0000, 1'b0, 1'b0);
    rd_lit("af_no_enable", 0, 16'h3456);

    // AF bank swapping.
    wr(0, 16'h1234, 1'b1, 1'b1);
    m_if.ex_af = 1'b1; cyc(); idle();
    wr(0, 16'hABCD, 1'b1, 1'b1);
    m_if.ex_af = 1'b1; cyc(); idle();
    rd_lit("af_bank0", 0, 16'h1234);
    bank_lit("af_bank_is0", 4'b0000);
    m_if.ex_af = 1'b1; cyc(); idle();
    rd_lit("af_bank1", 0, 16'hABCD);
    bank_lit("af_bank_is1", 4'b1000);

    // EXX and EX DE,HL.
    wr(2, 16'h1111, 1'b1, 1'b1);
    wr(3, 16'h2222, 1'b1, 1'b1);
    m_if.ex_dehl = 1'b1; cyc(); idle();
    rd_lit("de_swapped", 2, 16'h2222);
    rd_lit("hl_swapped", 3, 16'h1111);
    bank_lit("swap01", 4'b1001);
    m_if.exx = 1'b1; cyc(); idle();
    rd_lit("de_bank1", 2, 16'hFFFF);
    rd_lit("hl_bank1", 3, 16'hFFFF);
    bank_lit("gp_bank1", 4'b1101);
    m_if.exx = 1'b1; cyc(); idle();
    rd_lit("de_back", 2, 16'h2222);

    // Inc/dec wrap and write merge on the same pair.
    wr(6, 16'hFFFF, 1'b1, 1'b1);
    m_if.incdec_en = 1'b1; m_if.incdec_sel = 3'd6; m_if.incdec_dn = 1'b0; cyc(); idle();
    rd_lit("sp_inc_wrap", 6, 16'h0000);
    m_if.incdec_en = 1'b1; m_if.incdec_dn = 1'b1; cyc(); idle();
    rd_lit("sp_dec_wrap", 6, 16'hFFFF);
    wr(3, 16'h00FF, 1'b1, 1'b1);
    m_if.incdec_en = 1'b1; m_if.incdec_sel = 3'd3; m_if.incdec_dn = 1'b0;
    wr(3, 16'h1299, 1'b1, 1'b0);
    rd_lit("hl_hi_plus_inc", 3, 16'h1200);

    // Write mapped through the pre-edge swap state.
    m_if.ex_dehl = 1'b1;
    wr(2, 16'h5555, 1'b1, 1'b1);
    rd_lit("de_write_with_swap", 3, 16'h5555);
    rd_lit("de_after_swap", 2, 16'h1200);
    // All three swaps together; ex_dehl hits the pre-edge GP bank.
    m_if.ex_af = 1'b1; m_if.exx = 1'b1; m_if.ex_dehl = 1'b1; cyc(); idle();
    bank_lit("triple_swap", 4'b0101);

    // Mixed directed-random traffic, checked by the model every cycle.
    for (int i = 0; i < 80; i++) begin
      m_if.wr_sel     = 3'($urandom_range(0, 7));
      m_if.wr_data    = 16'($urandom);
      m_if.wr_hi      = 1'($urandom);
      m_if.wr_lo      = 1'($urandom);
      m_if.incdec_en  = 1'($urandom);
      m_if.incdec_dn  = 1'($urandom);
      m_if.incdec_sel = 3'($urandom_range(0, 7));
      m_if.ex_af      = ($urandom_range(0, 3) == 0);
      m_if.exx        = ($urandom_range(0, 3) == 0);
      m_if.ex_dehl    = ($urandom_range(0, 3) == 0);
      m_if.rd_sel_a   = 3'($urandom_range(0, 7));
      m_if.rd_sel_b   = 3'($urandom_range(0, 7));
      cyc();
    end
    idle();

    // Reset mid-write discards it; writes resume after release.
    m_if.wr_sel = 3'd4; m_if.wr_data = 16'hBEEF; m_if.wr_hi = 1'b1; m_if.wr_lo = 1'b1;
    @(negedge clk);
    #1 nreset = 1'b0;
    rd_lit("async_reset_ix", 4, 16'hFFFF);
    bank_lit("async_reset_banks", 4'b0000);
    cyc();
    rd_lit("reset_held_ix", 4, 16'hFFFF);
    for (int i = 0; i < 8; i++) rd_lit("reset_all", i, 16'hFFFF);
    nreset = 1'b1;
    #1;
    cyc();
    rd_lit("write_resumes", 4, 16'hBEEF);
    idle();

    // Out-of-range selects on a 5-pair instance.
    s_if.wr_sel = 3'd7; s_if.wr_data = 16'h1234; s_if.wr_hi = 1'b1; s_if.wr_lo = 1'b1;
    s_if.incdec_en = 1'b1; s_if.incdec_sel = 3'd6;
    cyc();
    s_if.wr_sel = 3'd4; s_if.wr_data = 16'h4444; s_if.incdec_en = 1'b0;
    cyc();
    s_if.wr_hi = 1'b0; s_if.wr_lo = 1'b0;
    s_if.ex_af = 1'b1; s_if.exx = 1'b1;
    cyc();
    s_if.ex_af = 1'b0; s_if.exx = 1'b0;
    s_lit("oor_rd5", 5, 16'h0000);
    s_lit("oor_rd6", 6, 16'h0000);
    s_lit("oor_rd7", 7, 16'h0000);
    s_lit("p4_write", 4, 16'h4444);
    s_lit("af1_untouched", 0, 16'hFFFF);
    s_lit("bc1_untouched", 1, 16'hFFFF);
    s_lit("de1_untouched", 2, 16'hFFFF);
    s_lit("hl1_untouched", 3, 16'hFFFF);

    cyc();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
